// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus bundle: address, strobes and acknowledge.
// DDT stays a plain inout on the controller so its tristate is visible.
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] DAD;
    logic              MREQ;
    logic              WRITE;
    logic [1:0]        SIZE;
    logic              ACKD_n;

    modport master (
        output DAD,
        output MREQ,
        output WRITE,
        output SIZE,
        input  ACKD_n
    );

    modport slave (
        input  DAD,
        input  MREQ,
        input  WRITE,
        input  SIZE,
        output ACKD_n
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus controller: ACKD_n wait states, lane steering,
// posted writes, timeout abort and misalignment detection.
module dmem_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8,
    parameter bit POST_WRITES = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              bus_err,
    dmem_bus_ctrl_if.master   bus,
    inout  wire  [31:0]       DDT
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        POSTED,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dad_q, dad_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mreq_q, mreq_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              mis;
    logic              ack;
    logic              to_hit;
    logic [TO_W-1:0]   cnt_inc;

    function automatic logic [31:0] store_lanes(
        input logic [31:0] d,
        input logic [1:0]  sz
    );
        logic [31:0] r;
        unique case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Big-endian: byte address 0 lives on DDT[31:24].
    function automatic logic [31:0] load_lanes(
        input logic [31:0] d,
        input logic [1:0]  a,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (a)
            2'b00:   b = d[31:24];
            2'b01:   b = d[23:16];
            2'b10:   b = d[15:8];
            default: b = d[7:0];
        endcase
        h = a[1] ? d[15:0] : d[31:16];
        unique case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept  = req_read | req_write;
    assign mis     = (req_size == 2'b01 && req_addr[0])
                   | (req_size[1] && req_addr[1:0] != 2'b00);
    assign ack     = mreq_q & ~bus.ACKD_n;
    assign cnt_inc = cnt_q + 1'b1;
    assign to_hit  = (cnt_inc == TO_W'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        dad_d    = dad_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        mreq_d   = mreq_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_d    = '0;
        stall    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall = mis | ~(req_write & POST_WRITES);
                    if (mis) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (!req_write) rdata_d = '0;
                    end else begin
                        dad_d    = req_addr;
                        size_d   = (req_size == 2'b11) ? 2'b10 : req_size;
                        signed_d = req_signed;
                        wdata_d  = store_lanes(req_wdata, req_size);
                        mreq_d   = 1'b1;
                        write_d  = req_write;
                        state_d  = (req_write && POST_WRITES) ? POSTED
                                                              : ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (ack) begin
                    mreq_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                    if (!write_q) begin
                        rdata_d = load_lanes(DDT, dad_q[1:0],
                                             size_q, signed_q);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        mreq_d  = 1'b0;
                        write_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (!write_q) rdata_d = '0;
                    end
                end
            end
            POSTED: begin
                // Pipeline only waits if it already has the next access.
                stall = accept;
                if (ack) begin
                    mreq_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        mreq_d  = 1'b0;
                        write_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dad_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            mreq_q   <= 1'b0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dad_q    <= dad_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            mreq_q   <= mreq_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.DAD   = dad_q;
    assign bus.MREQ  = mreq_q;
    assign bus.WRITE = write_q;
    assign bus.SIZE  = size_q;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign DDT       = write_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: blocking and posted-write instances
// driven by a cycle-level bus slave, load results checked from a queue.
module tb_dmem_bus_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]       req_read, req_write, req_signed;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][1:0]  req_size;
    logic [1:0]       ack, drv;
    logic [1:0][31:0] rd_val;

    wire [1:0]       stall, bus_err, mreq, wr;
    wire [1:0][31:0] rdata, dad, ddt_rd;
    wire [1:0][1:0]  size;
    wire [31:0]      ddt0, ddt1;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_bus_ctrl_if #(.ADDR_W(32)) bus0 ();
    dmem_bus_ctrl_if #(.ADDR_W(32)) bus1 ();

    assign bus0.ACKD_n = ack[0];
    assign bus1.ACKD_n = ack[1];
    assign mreq[0] = bus0.MREQ;
    assign mreq[1] = bus1.MREQ;
    assign wr[0]   = bus0.WRITE;
    assign wr[1]   = bus1.WRITE;
    assign dad[0]  = bus0.DAD;
    assign dad[1]  = bus1.DAD;
    assign size[0] = bus0.SIZE;
    assign size[1] = bus1.SIZE;
    assign ddt0 = drv[0] ? rd_val[0] : 32'bz;
    assign ddt1 = drv[1] ? rd_val[1] : 32'bz;
    assign ddt_rd[0] = ddt0;
    assign ddt_rd[1] = ddt1;

    dmem_bus_ctrl #(
        .ADDR_W(32), .TIMEOUT(8), .TO_W(8), .POST_WRITES(1'b0)
    ) u0 (
        .clk(clk), .rst(rst),
        .req_read(req_read[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]),
        .stall(stall[0]), .rdata(rdata[0]), .bus_err(bus_err[0]),
        .bus(bus0.master), .DDT(ddt0)
    );

    dmem_bus_ctrl #(
        .ADDR_W(32), .TIMEOUT(4), .TO_W(8), .POST_WRITES(1'b1)
    ) u1 (
        .clk(clk), .rst(rst),
        .req_read(req_read[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]),
        .stall(stall[1]), .rdata(rdata[1]), .bus_err(bus_err[1]),
        .bus(bus1.master), .DDT(ddt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic load(input int d, input logic [31:0] a,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] mem, input logic [31:0] exp);
        @(posedge clk);
        #1;
        req_read[d]   = 1'b1;
        req_write[d]  = 1'b0;
        req_addr[d]   = a;
        req_size[d]   = sz;
        req_signed[d] = sg;
        rd_val[d]     = mem;
        push_exp(d, exp);
    endtask

    // Bus slave: acks the (wt+1)-th cycle of each MREQ burst; runs until
    // the pipeline is released, then checks the observed cycle counts.
    task automatic serve(input int d, input int wt, input logic [31:0] wd,
                         input int e_stall, input int e_mreq,
                         input int e_wr, input int e_err, input string tag);
        int ns, nm, nw, ne, run, bad_dad, bad_wd;
        logic [31:0] dad0, ev;
        bit released;
        ns = 0; nm = 0; nw = 0; ne = 0; run = 0;
        bad_dad = 0; bad_wd = 0; released = 1'b0; dad0 = '0;
        for (int c = 0; c < 60 && !released; c++) begin
            @(negedge clk);
            if (bus_err[d]) ne++;
            if (mreq[d]) begin
                nm++;
                if (run == 0) dad0 = dad[d];
                else if (dad[d] !== dad0) bad_dad++;
                run++;
                if (wr[d]) begin
                    nw++;
                    if (ddt_rd[d] !== wd) bad_wd++;
                end
            end else begin
                run = 0;
            end
            if (stall[d]) ns++;
            else released = 1'b1;
            if (released) begin
                req_read[d]  = 1'b0;
                req_write[d] = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    ev = q0.pop_front();
                    chk({tag, " rdata"}, rdata[d], ev);
                end else if (d == 1 && q1.size() > 0) begin
                    ev = q1.pop_front();
                    chk({tag, " rdata"}, rdata[d], ev);
                end
            end
            ack[d] = !(mreq[d] && run > wt);
            drv[d] = mreq[d] && !wr[d] && run > wt;
        end
        chk({tag, " released"}, 32'(released), 32'd1);
        chk({tag, " stall cycles"}, ns, e_stall);
        chk({tag, " mreq cycles"}, nm, e_mreq);
        chk({tag, " write cycles"}, nw, e_wr);
        chk({tag, " err pulses"}, ne, e_err);
        chk({tag, " dad stable"}, bad_dad, 0);
        chk({tag, " ddt lanes"}, bad_wd, 0);
        @(negedge clk);
        chk({tag, " err cleared"}, 32'(bus_err[d]), 32'd0);
        chk({tag, " mreq idle"}, 32'(mreq[d]), 32'd0);
        ack[d] = 1'b1;
        drv[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_read = '0; req_write = '0; req_signed = '0;
        req_addr = '0; req_wdata = '0; req_size = '0;
        ack = 2'b11; drv = '0; rd_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk("rst stall", 32'(stall[d]), 32'd0);
            chk("rst rdata", rdata[d], 32'd0);
            chk("rst bus_err", 32'(bus_err[d]), 32'd0);
            chk("rst dad", dad[d], 32'd0);
            chk("rst mreq", 32'(mreq[d]), 32'd0);
            chk("rst write", 32'(wr[d]), 32'd0);
            chk("rst size", 32'(size[d]), 32'd0);
        end

        // Acknowledge with no bus cycle in flight must be ignored.
        @(negedge clk);
        ack[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("stray ack mreq", 32'(mreq[0]), 32'd0);
        chk("stray ack stall", 32'(stall[0]), 32'd0);
        @(negedge clk);
        chk("stray ack err", 32'(bus_err[0]), 32'd0);
        ack[0] = 1'b1;

        load(0, 32'h0000_1001, 2'b00, 1'b1, 32'h1280_3456, 32'hFFFF_FF80);
        serve(0, 0, 32'h0, 2, 1, 0, 0, "sbyte");
        chk("sbyte dad", dad[0], 32'h0000_1001);

        load(0, 32'h0000_2002, 2'b01, 1'b0, 32'h1234_8765, 32'h0000_8765);
        serve(0, 2, 32'h0, 4, 3, 0, 0, "uhalf");

        load(0, 32'h0000_2000, 2'b01, 1'b1, 32'h8765_1234, 32'hFFFF_8765);
        serve(0, 0, 32'h0, 2, 1, 0, 0, "shalf");

        load(0, 32'h0000_3003, 2'b00, 1'b0, 32'h1234_56F0, 32'h0000_00F0);
        serve(0, 1, 32'h0, 3, 2, 0, 0, "ubyte");

        load(0, 32'h0000_4000, 2'b10, 1'b0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        serve(0, 5, 32'h0, 7, 6, 0, 0, "word wait5");
        chk("word size", 32'(size[0]), 32'd2);

        load(0, 32'h0000_5002, 2'b10, 1'b0, 32'h1111_1111, 32'h0);
        serve(0, 0, 32'h0, 1, 0, 0, 1, "misaligned");

        @(posedge clk);
        #1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_6001;
        req_size[0]  = 2'b00;
        req_wdata[0] = 32'h0000_007E;
        serve(0, 1, 32'h7E7E_7E7E, 3, 2, 2, 0, "store byte");

        // Reset in the middle of a blocking store.
        @(posedge clk);
        #1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_size[0]  = 2'b10;
        req_wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk("pre-rst mreq", 32'(mreq[0]), 32'd1);
        chk("pre-rst write", 32'(wr[0]), 32'd1);
        chk("pre-rst ddt", ddt_rd[0], 32'hDEAD_BEEF);
        rst = 1'b1;
        req_write[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-rst mreq", 32'(mreq[0]), 32'd0);
        chk("mid-rst write", 32'(wr[0]), 32'd0);
        chk("mid-rst stall", 32'(stall[0]), 32'd0);
        chk("mid-rst err", 32'(bus_err[0]), 32'd0);
        rd_val[0] = 32'h5A5A_5A5A;
        drv[0] = 1'b1;
        #1;
        chk("mid-rst ddt released", ddt_rd[0], 32'h5A5A_5A5A);
        drv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("post-rst err", 32'(bus_err[0]), 32'd0);

        // Posted half store followed immediately by a load.
        @(posedge clk);
        #1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0000_0002;
        req_size[1]  = 2'b01;
        req_wdata[1] = 32'h0000_ABCD;
        @(negedge clk);
        chk("posted stall", 32'(stall[1]), 32'd0);
        load(1, 32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        chk("posted mreq", 32'(mreq[1]), 32'd1);
        chk("posted write", 32'(wr[1]), 32'd1);
        chk("posted dad", dad[1], 32'h0000_0002);
        chk("posted size", 32'(size[1]), 32'd1);
        serve(1, 3, 32'hABCD_ABCD, 9, 8, 4, 0, "posted+load");
        chk("load dad", dad[1], 32'h0000_0010);

        load(1, 32'h0000_7000, 2'b10, 1'b0, 32'h0, 32'h0);
        serve(1, 100, 32'h0, 5, 4, 0, 1, "timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
